// File: rtl/udar_pkg.sv
// Shared definitions for the scanning range-finder controller.
//   scan_state_t : sweep FSM states
//   CAP_LEN_DEF  : default width of a measured range length
//   ANG_LEN_DEF  : default width of a servo angle code
//   cnt_width()  : width of the shared settle/measure down-counter
package udar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_EMIT,
        ST_STEP
    } scan_state_t;

    localparam int CAP_LEN_DEF = 8;
    localparam int ANG_LEN_DEF = 8;

    // The counter must hold the larger of the two load values.
    function automatic int cnt_width(input int settle, input int meas_to);
        int longest;
        longest = (settle > meas_to) ? settle : meas_to;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/scan_ctrl_cyc_timer.sv
// cyc_timer: loadable down-counter with a one-cycle expire indication.
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : number of cycles until expire, counting the first loaded cycle
//   expire   : high during the last cycle of a loaded interval (count == 1)
// The count stops at zero, so expire fires once per load.
module cyc_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == W'(1));

endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: servo sweep controller for a ranging sensor.
// Steps a servo angle, waits for it to settle, runs one range measurement
// (with timeout) and hands out one {angle, length, timeout} record per
// angle over a valid/ready interface.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   start/stop : single-cycle sweep start / stop requests
//   meas_en    : enable to the ranging driver (high while measuring)
//   meas_done  : measurement-complete pulse, meas_len valid with it
//   angle      : servo angle code
//   busy       : high in any state except IDLE
//   out_valid/out_ready, out_angle/out_len/out_to : result record
// Build option: define SCAN_CTRL_PINGPONG_EN for an up/down sweep;
// otherwise the angle wraps from ANG_MAX back to 0.
module scan_ctrl
    import udar_pkg::*;
#(
    parameter int CAP_LEN = CAP_LEN_DEF,
    parameter int ANG_LEN = ANG_LEN_DEF,
    parameter int ANG_MAX = 180,
    parameter int SETTLE  = 1000,
    parameter int MEAS_TO = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    output logic               meas_en,
    input  logic               meas_done,
    input  logic [CAP_LEN-1:0] meas_len,
    output logic [ANG_LEN-1:0] angle,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ANG_LEN-1:0] out_angle,
    output logic [CAP_LEN-1:0] out_len,
    output logic               out_to
);

    localparam int                 CNT_W   = cnt_width(SETTLE, MEAS_TO);
    localparam logic [ANG_LEN-1:0] ANG_TOP = ANG_LEN'(ANG_MAX);

    scan_state_t        state, state_nxt;
    logic               run_ok;
    logic               stop_pend;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_expire;
    logic [ANG_LEN-1:0] angle_nxt;
    logic               sweep_go;
    logic               stop_now;

    // Held low through reset and for the first edge after release, so the
    // FSM cannot leave IDLE on the very first cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_ok <= 1'b0;
        end else begin
            run_ok <= 1'b1;
        end
    end

    assign sweep_go = start && !stop && run_ok;
    assign stop_now = stop_pend || stop;

    // One timer serves both SETTLE and MEASURE; it is reloaded on every
    // entry into either state.
    cyc_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state)
            ST_IDLE: begin
                if (sweep_go) begin
                    state_nxt = ST_SETTLE;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(SETTLE);
                end
            end
            ST_SETTLE: begin
                if (tmr_expire) begin
                    state_nxt = ST_MEASURE;
                    tmr_load  = 1'b1;
                    tmr_val   = CNT_W'(MEAS_TO);
                end
            end
            ST_MEASURE: begin
                if (meas_done || tmr_expire) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    state_nxt = stop_now ? ST_IDLE : ST_STEP;
                end
            end
            ST_STEP: begin
                state_nxt = ST_SETTLE;
                tmr_load  = 1'b1;
                tmr_val   = CNT_W'(SETTLE);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef SCAN_CTRL_PINGPONG_EN
    logic dir_up;
    logic dir_nxt;

    // Endpoints are visited once per turnaround: the step that reaches an
    // end flips direction on the following step.
    always_comb begin
        angle_nxt = angle;
        dir_nxt   = dir_up;
        if (dir_up) begin
            if (angle == ANG_TOP) begin
                angle_nxt = angle - ANG_LEN'(1);
                dir_nxt   = 1'b0;
            end else begin
                angle_nxt = angle + ANG_LEN'(1);
            end
        end else begin
            if (angle == '0) begin
                angle_nxt = ANG_LEN'(1);
                dir_nxt   = 1'b1;
            end else begin
                angle_nxt = angle - ANG_LEN'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_up <= 1'b1;
        end else if (state == ST_IDLE && sweep_go) begin
            dir_up <= 1'b1;
        end else if (state == ST_STEP) begin
            dir_up <= dir_nxt;
        end
    end
`else
    always_comb begin
        angle_nxt = (angle == ANG_TOP) ? '0 : angle + ANG_LEN'(1);
    end
`endif

    // Angle holds in IDLE after a stop; only reset or a new start clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            angle <= '0;
        end else if (state == ST_IDLE && sweep_go) begin
            angle <= '0;
        end else if (state == ST_STEP) begin
            angle <= angle_nxt;
        end
    end

    // Record capture; done on the timeout cycle still counts as a result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_angle <= '0;
            out_len   <= '0;
            out_to    <= 1'b0;
        end else if (state == ST_MEASURE) begin
            if (meas_done) begin
                out_angle <= angle;
                out_len   <= meas_len;
                out_to    <= 1'b0;
            end else if (tmr_expire) begin
                out_angle <= angle;
                out_len   <= '1;
                out_to    <= 1'b1;
            end
        end
    end

    // A stop while busy is remembered until the current record is handed off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_pend <= 1'b0;
        end else if (state_nxt == ST_IDLE) begin
            stop_pend <= 1'b0;
        end else if (state != ST_IDLE && stop) begin
            stop_pend <= 1'b1;
        end
    end

    assign meas_en   = (state == ST_MEASURE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_EMIT);

endmodule

// File: tb/tb_scan_ctrl.sv
// Self-checking bench for scan_ctrl with ANG_MAX=3, SETTLE=4, MEAS_TO=16.
// A table of per-angle measurements drives a full sweep; hand-written
// sequences cover back-pressure, stop, reset during EMIT and IDLE corners.
module tb_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       meas_en;
    logic       meas_done;
    logic [7:0] meas_len;
    logic [7:0] angle;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_angle;
    logic [7:0] out_len;
    logic       out_to;

    int checks   = 0;
    int failures = 0;

    scan_ctrl #(
        .CAP_LEN (8),
        .ANG_LEN (8),
        .ANG_MAX (3),
        .SETTLE  (4),
        .MEAS_TO (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .meas_en   (meas_en),
        .meas_done (meas_done),
        .meas_len  (meas_len),
        .angle     (angle),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
        .out_len   (out_len),
        .out_to    (out_to)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         d;         // MEASURE cycle carrying meas_done, 0 = never
        logic [7:0] len;
        logic [7:0] exp_angle;
        logic [7:0] exp_len;
        logic       exp_to;
        int         exp_pre;   // busy cycles before meas_en rises
        int         exp_en;    // cycles meas_en stays high
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] ang_seq [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge while busy; returns at the negedge where meas_en
    // has dropped again (first EMIT cycle).
    task automatic run_meas(input int d, input logic [7:0] len, input int stop_at,
                            output int pre, output int en);
        int guard;
        guard = 0;
        pre   = 0;
        en    = 0;
        while (!meas_en && guard < 200) begin
            if (busy) pre++;
            @(negedge clk);
            guard++;
        end
        check("meas_en_seen", 32'(meas_en), 32'd1);
        while (meas_en && en < 200) begin
            en++;
            meas_done = (en == d);
            meas_len  = (en == d) ? len : 8'h00;
            stop      = (en == stop_at);
            @(negedge clk);
        end
        meas_done = 1'b0;
        meas_len  = 8'h00;
        stop      = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_meas_en"},   32'(meas_en),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_angle"},     32'(angle),     32'd0);
        check({tag, "_out_angle"}, 32'(out_angle), 32'd0);
        check({tag, "_out_len"},   32'(out_len),   32'd0);
        check({tag, "_out_to"},    32'(out_to),    32'd0);
    endtask

    initial begin
        int pre;
        int en;

`ifdef SCAN_CTRL_PINGPONG_EN
        ang_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3};
`else
        ang_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0, 8'd1};
`endif
        vecs[0] = '{d:3,  len:8'h2A, exp_angle:ang_seq[0], exp_len:8'h2A, exp_to:1'b0, exp_pre:4, exp_en:3};
        vecs[1] = '{d:1,  len:8'h11, exp_angle:ang_seq[1], exp_len:8'h11, exp_to:1'b0, exp_pre:5, exp_en:1};
        vecs[2] = '{d:0,  len:8'h77, exp_angle:ang_seq[2], exp_len:8'hFF, exp_to:1'b1, exp_pre:5, exp_en:16};
        vecs[3] = '{d:16, len:8'h5C, exp_angle:ang_seq[3], exp_len:8'h5C, exp_to:1'b0, exp_pre:5, exp_en:16};
        vecs[4] = '{d:7,  len:8'h00, exp_angle:ang_seq[4], exp_len:8'h00, exp_to:1'b0, exp_pre:5, exp_en:7};
        vecs[5] = '{d:2,  len:8'hFF, exp_angle:ang_seq[5], exp_len:8'hFF, exp_to:1'b0, exp_pre:5, exp_en:2};
        vecs[6] = '{d:15, len:8'h80, exp_angle:ang_seq[6], exp_len:8'h80, exp_to:1'b0, exp_pre:5, exp_en:15};
        vecs[7] = '{d:4,  len:8'h01, exp_angle:ang_seq[7], exp_len:8'h01, exp_to:1'b0, exp_pre:5, exp_en:4};

        rst       = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        meas_done = 1'b0;
        meas_len  = 8'h00;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // Start on the first cycle after release is ignored
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("release_start_ignored", 32'(busy), 32'd0);

        // Start together with stop stays in IDLE
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (3) @(negedge clk);
        check("start_stop_idle_busy", 32'(busy), 32'd0);

        // meas_done outside MEASURE is ignored
        meas_done = 1'b1;
        meas_len  = 8'h99;
        @(negedge clk);
        meas_done = 1'b0;
        meas_len  = 8'h00;
        @(negedge clk);
        check("idle_done_busy",  32'(busy),      32'd0);
        check("idle_done_valid", 32'(out_valid), 32'd0);
        check("idle_done_len",   32'(out_len),   32'd0);

        // Table-driven sweep with out_ready held high
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_meas(vecs[i].d, vecs[i].len, 0, pre, en);
            check($sformatf("v%0d_settle", i),    32'(pre),       32'(vecs[i].exp_pre));
            check($sformatf("v%0d_meas_en", i),   32'(en),        32'(vecs[i].exp_en));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_out_angle", i), 32'(out_angle), 32'(vecs[i].exp_angle));
            check($sformatf("v%0d_angle", i),     32'(angle),     32'(vecs[i].exp_angle));
            check($sformatf("v%0d_out_len", i),   32'(out_len),   32'(vecs[i].exp_len));
            check($sformatf("v%0d_out_to", i),    32'(out_to),    32'(vecs[i].exp_to));
            @(negedge clk);
        end

        // Back-pressure: record held stable for 10 cycles, then one transfer
        out_ready = 1'b0;
        run_meas(5, 8'h33, 0, pre, en);
        check("bp_settle", 32'(pre), 32'd5);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_angle", k), 32'(out_angle), 32'(ang_seq[8]));
            check($sformatf("bp%0d_len", k),   32'(out_len),   32'h33);
            check($sformatf("bp%0d_to", k),    32'(out_to),    32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_single_transfer", 32'(out_valid), 32'd0);
        check("bp_step_busy",       32'(busy),      32'd1);
        out_ready = 1'b0;

        // Reset asserted during EMIT clears everything before the next edge
        run_meas(2, 8'h44, 0, pre, en);
        check("rst_emit_valid", 32'(out_valid), 32'd1);
        check("rst_emit_angle", 32'(out_angle), 32'(ang_seq[9]));
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        pre       = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid || busy) pre++;
        end
        check("post_rst_quiet", 32'(pre), 32'd0);

        // Stop during MEASURE at angle 2: record emitted, then IDLE at angle 2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        run_meas(2, 8'h10, 0, pre, en);
        check("stop_rec0_angle", 32'(out_angle), 32'd0);
        @(negedge clk);
        run_meas(2, 8'h20, 0, pre, en);
        check("stop_rec1_angle", 32'(out_angle), 32'd1);
        @(negedge clk);
        run_meas(3, 8'h5A, 2, pre, en);
        check("stop_rec2_valid", 32'(out_valid), 32'd1);
        check("stop_rec2_angle", 32'(out_angle), 32'd2);
        check("stop_rec2_len",   32'(out_len),   32'h5A);
        @(negedge clk);
        check("stop_idle_busy",  32'(busy),      32'd0);
        check("stop_idle_valid", 32'(out_valid), 32'd0);
        check("stop_idle_angle", 32'(angle),     32'd2);
        repeat (5) @(negedge clk);
        check("stop_hold_busy",  32'(busy),      32'd0);
        check("stop_hold_angle", 32'(angle),     32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
